high_score_reader: RTL and testbench
====================================

Name: high_score_reader

Overview:
Owns the single-port score RAM that stores end-of-game scores. Writes each final score into a circular buffer and continuously scans the valid entries to publish the all-time largest score. Sits between the score counter / game-state FSM (write side) and the HEX/score display logic (read side). It is the sole driver of the RAM address, write enable and write data.

Parameters:
DEPTH, 32, number of score RAM entries
SCORE_W, 11, score width in bits
READ_LAT, 1, RAM read latency in cycles from address to valid mem_q (1 or 2)
AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
wr_req  input  1  single-cycle pulse: store wr_data as a finished-game score
wr_data  input  SCORE_W  score to store, sampled when wr_req=1
mem_address  output  AW  RAM address
mem_data  output  SCORE_W  RAM write data
mem_wren  output  1  RAM write enable
mem_q  input  SCORE_W  RAM read data, valid READ_LAT cycles after address
largest_value  output  SCORE_W  published high score
largest_valid  output  1  at least one score stored
fill_count  output  AW+1  number of valid entries, saturates at DEPTH
scan_busy  output  1  a scan pass is in progress

Behaviour:
- Reset (reset=0, async): wr_ptr=0, fill_count=0, largest_value=0, largest_valid=0, mem_wren=0, mem_address=0, mem_data=0, scan_busy=0, running max=0, read-tag pipeline cleared, state IDLE.
- Write path: wr_req/wr_data registered. In the cycle after the wr_req pulse: mem_wren=1, mem_address=wr_ptr, mem_data=captured data. At the end of that cycle: wr_ptr increments, wrapping DEPTH-1 to 0; fill_count increments, saturating at DEPTH; the oldest entry is overwritten once full.
- Back-to-back wr_req pulses produce consecutive write cycles. No request is dropped.
- Fast path: the write cycle updates largest_value to max(largest_value, written data) and sets largest_valid=1, visible the next cycle.
- Write priority: a write cycle always wins the address over scanning.
- States: IDLE, SCAN, DRAIN, WRITE.
- IDLE: mem_wren=0. Go to SCAN when fill_count>0; stay in IDLE when fill_count=0.
- SCAN: issue address idx = 0..fill_count-1, one per cycle. Each issued read carries a valid tag, delayed READ_LAT cycles. When the tag emerges, running max = max(running max, mem_q). After the last index, go to DRAIN.
- DRAIN: wait until all tags emerge. Then commit: largest_value = running max. Clear running max and return to SCAN at index 0 the next cycle, so scanning is continuous.
- The commit may lower largest_value when the previous maximum has been overwritten. This is intended: the value reflects the buffer contents.
- WRITE, entered from any state on a registered wr_req: flush all in-flight read tags, discard the running max (no partial-pass commit), and perform the write. The next cycle enters SCAN at index 0.
- scan_busy=1 in SCAN and DRAIN; 0 in IDLE and WRITE.
- Compares are unsigned at SCORE_W bits. Equal values leave the max unchanged.
- fill_count reflects the post-write value during the pass that follows the write; the scan bound is latched at SCAN entry.
- Reset asserted mid-pass or mid-write: immediate return to reset values; no write completes after reset asserts.

Test Plan:
- Reset, then idle 20 cycles -> largest_value=0, largest_valid=0, fill_count=0, mem_wren never 1, scan_busy=0.
- Pulses 5, 17, 3, spaced 10 cycles apart -> writes at addresses 0, 1, 2 one cycle after each pulse. largest_value reads 5, then 17, and stays 17. fill_count=3. Scans cycle through addresses 0..2.
- Back-to-back pulses 9 then 12 from reset -> mem_wren high 2 consecutive cycles at addresses 0 and 1. largest_value=12 and fill_count=2.
- Write 100, then 31 writes of 1, then one write of 2 (overwrites address 0) -> fill_count=32 and wr_ptr=1. largest_value stays 100 until the first full pass after the last write commits, then becomes 2.
- Pulse while in SCAN at index 4 of 10, with READ_LAT=2 -> in-flight reads discarded and no commit. The cycle after the write, mem_address=0. The next commit includes the new entry.
- Assert reset during DRAIN -> all outputs return to reset values asynchronously before the next clk edge.

Source files
------------

// File: rtl/high_score_reader.sv
// Score RAM owner: stores final scores in a circular buffer and rescans it continuously to publish the high score.
// Writes take one cycle after wr_req and always preempt a scan pass; a pass over N entries takes N + READ_LAT cycles.
module high_score_reader #(
  parameter int DEPTH    = 32,
  parameter int SCORE_W  = 11,
  parameter int READ_LAT = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_req,
  input  logic [SCORE_W-1:0] wr_data,
  output logic [AW-1:0]      mem_address,
  output logic [SCORE_W-1:0] mem_data,
  output logic               mem_wren,
  input  logic [SCORE_W-1:0] mem_q,
  output logic [SCORE_W-1:0] largest_value,
  output logic               largest_valid,
  output logic [AW:0]        fill_count,
  output logic               scan_busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, WRITE} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t             state;
  logic [AW-1:0]      wr_ptr;
  logic [AW:0]        scan_n;
  logic [SCORE_W-1:0] run_max;
  // tag[k] marks that the address issued k cycles ago was a scan read
  logic [READ_LAT:0]  tag;

  logic [AW:0]        fill_next;
  logic [AW-1:0]      wr_ptr_next;
  logic [SCORE_W-1:0] max_next;
  logic               last_idx;
  logic               tags_done;

  assign fill_next   = (fill_count == FULL) ? fill_count : fill_count + (AW+1)'(1);
  assign wr_ptr_next = (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
  assign max_next    = (tag[READ_LAT] && (mem_q > run_max)) ? mem_q : run_max;
  assign last_idx    = ({1'b0, mem_address} == scan_n - (AW+1)'(1));
  assign tags_done   = (tag[READ_LAT-1:0] == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      fill_count    <= '0;
      scan_n        <= '0;
      run_max       <= '0;
      tag           <= '0;
      largest_value <= '0;
      largest_valid <= 1'b0;
      mem_address   <= '0;
      mem_data      <= '0;
      mem_wren      <= 1'b0;
      scan_busy     <= 1'b0;
    end else begin
      tag[READ_LAT:1] <= tag[READ_LAT-1:0];
      tag[0]          <= 1'b0;
      mem_wren        <= 1'b0;

      // the write issued last cycle completes now; mem_data still holds its value
      if (state == WRITE) begin
        wr_ptr        <= wr_ptr_next;
        fill_count    <= fill_next;
        largest_valid <= 1'b1;
        if (mem_data > largest_value)
          largest_value <= mem_data;
      end

      if (wr_req) begin
        state       <= WRITE;
        mem_wren    <= 1'b1;
        mem_address <= (state == WRITE) ? wr_ptr_next : wr_ptr;
        mem_data    <= wr_data;
        tag         <= '0;
        run_max     <= '0;
        scan_busy   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (fill_count != '0) begin
              state       <= SCAN;
              mem_address <= '0;
              tag[0]      <= 1'b1;
              scan_n      <= fill_count;
              scan_busy   <= 1'b1;
            end
          end
          WRITE: begin
            state       <= SCAN;
            mem_address <= '0;
            tag[0]      <= 1'b1;
            scan_n      <= fill_next;
            scan_busy   <= 1'b1;
          end
          SCAN: begin
            run_max <= max_next;
            if (last_idx) begin
              state <= DRAIN;
            end else begin
              mem_address <= mem_address + AW'(1);
              tag[0]      <= 1'b1;
            end
          end
          DRAIN: begin
            if (tags_done) begin
              largest_value <= max_next;
              run_max       <= '0;
              state         <= SCAN;
              mem_address   <= '0;
              tag[0]        <= 1'b1;
              scan_n        <= fill_count;
            end else begin
              run_max <= max_next;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_high_score_reader.sv
// Bench: two instances (READ_LAT=1 and 2) with RAM models, checked every cycle against a buffer-level reference.
module tb_high_score_reader;
  localparam int DEPTH = 32;
  localparam int SW    = 11;
  localparam int AW    = 5;
  localparam int M_IDLE = 0, M_PASS = 1, M_WRITE = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_req = 1'b0;
  logic [SW-1:0] wr_data = '0;

  logic [AW-1:0] m_addr [2];
  logic [SW-1:0] m_data [2];
  logic          m_wren [2];
  logic [SW-1:0] m_q    [2];
  logic [SW-1:0] m_lval [2];
  logic          m_lvld [2];
  logic [AW:0]   m_fill [2];
  logic          m_busy [2];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  high_score_reader #(.DEPTH(DEPTH), .SCORE_W(SW), .READ_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_data(wr_data),
    .mem_address(m_addr[0]), .mem_data(m_data[0]), .mem_wren(m_wren[0]), .mem_q(m_q[0]),
    .largest_value(m_lval[0]), .largest_valid(m_lvld[0]), .fill_count(m_fill[0]), .scan_busy(m_busy[0]));

  high_score_reader #(.DEPTH(DEPTH), .SCORE_W(SW), .READ_LAT(2)) u_dut2 (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_data(wr_data),
    .mem_address(m_addr[1]), .mem_data(m_data[1]), .mem_wren(m_wren[1]), .mem_q(m_q[1]),
    .largest_value(m_lval[1]), .largest_valid(m_lvld[1]), .fill_count(m_fill[1]), .scan_busy(m_busy[1]));

  // synchronous RAMs: one read register for instance 1, two for instance 2
  logic [SW-1:0] ram [2][DEPTH];
  logic [SW-1:0] q2a;
  initial for (int a = 0; a < DEPTH; a++) begin ram[0][a] = '0; ram[1][a] = '0; end
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (m_wren[i]) ram[i][m_addr[i]] <= m_data[i];
    m_q[0] <= ram[0][m_addr[0]];
    q2a    <= ram[1][m_addr[1]];
    m_q[1] <= q2a;
  end

  // reference: buffer contents plus per-instance pass timer; a pass over n entries lasts n+READ_LAT cycles
  int sbuf [DEPTH];
  int wr_ptr_m, fill_m, wr_addr_m, wr_val_m;
  bit wr_act;
  int mode [2], pt [2], pn [2], lg [2];
  bit lv [2];

  function automatic int buf_max(input int n);
    int m = 0;
    for (int k = 0; k < n; k++) if (sbuf[k] > m) m = sbuf[k];
    return m;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      wr_ptr_m = 0; fill_m = 0; wr_act = 0; wr_addr_m = 0; wr_val_m = 0;
      for (int i = 0; i < 2; i++) begin mode[i] = M_IDLE; pt[i] = 0; pn[i] = 0; lg[i] = 0; lv[i] = 0; end
    end else begin
      if (wr_act) begin
        sbuf[wr_ptr_m] = wr_val_m;
        wr_ptr_m = (wr_ptr_m + 1) % DEPTH;
        if (fill_m < DEPTH) fill_m++;
        for (int i = 0; i < 2; i++) begin
          if (wr_val_m > lg[i]) lg[i] = wr_val_m;
          lv[i] = 1;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (wr_req) mode[i] = M_WRITE;
        else if (mode[i] == M_WRITE || (mode[i] == M_IDLE && fill_m > 0)) begin
          mode[i] = M_PASS; pt[i] = 0; pn[i] = fill_m;
        end else if (mode[i] == M_PASS) begin
          if (pt[i] == pn[i] + i) begin
            lg[i] = buf_max(pn[i]); pt[i] = 0; pn[i] = fill_m;
          end else pt[i]++;
        end
      end
      wr_act = wr_req; wr_val_m = int'(wr_data); wr_addr_m = wr_ptr_m;
    end
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", nm, i + 1, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("largest_value", i, 32'(m_lval[i]), lg[i]);
        chk("largest_valid", i, 32'(m_lvld[i]), 32'(lv[i]));
        chk("fill_count",    i, 32'(m_fill[i]), fill_m);
        chk("scan_busy",     i, 32'(m_busy[i]), (mode[i] == M_PASS) ? 1 : 0);
        chk("mem_wren",      i, 32'(m_wren[i]), (mode[i] == M_WRITE) ? 1 : 0);
        if (mode[i] == M_WRITE) begin
          chk("write_address", i, 32'(m_addr[i]), wr_addr_m);
          chk("write_data",    i, 32'(m_data[i]), wr_val_m);
        end else if (mode[i] == M_PASS && pt[i] < pn[i]) begin
          chk("scan_address", i, 32'(m_addr[i]), pt[i]);
        end else if (mode[i] == M_IDLE) begin
          chk("idle_address", i, 32'(m_addr[i]), 0);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int v);
    @(negedge clk);
    wr_req = 1'b1; wr_data = SW'(v);
    @(negedge clk);
    wr_req = 1'b0;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    wr_req = 1'b0;
    reset  = 1'b0;
    cyc(2);
    reset  = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic lit_both(input string nm, input int sel, input int exp);
    for (int i = 0; i < 2; i++)
      case (sel)
        0: chk(nm, i, 32'(m_lval[i]), exp);
        1: chk(nm, i, 32'(m_lvld[i]), exp);
        2: chk(nm, i, 32'(m_fill[i]), exp);
        default: chk(nm, i, 32'(m_busy[i]), exp);
      endcase
  endtask

  int scan_vals [10] = '{50, 600, 7, 1200, 33, 90, 45, 800, 11, 300};

  initial begin
    int k;
    bit found;
    // reset and idle
    do_reset();
    cyc(20);
    lit_both("idle_largest", 0, 0);
    lit_both("idle_valid", 1, 0);
    lit_both("idle_fill", 2, 0);
    lit_both("idle_busy", 3, 0);

    // spaced writes 5, 17, 3
    pulse(5);  cyc(10); lit_both("lit_after_5", 0, 5);
    pulse(17); cyc(10); lit_both("lit_after_17", 0, 17);
    pulse(3);  cyc(10); lit_both("lit_after_3", 0, 17);
    lit_both("lit_fill_3", 2, 3);

    // back-to-back 9 then 12
    do_reset();
    @(negedge clk); wr_req = 1'b1; wr_data = 11'd9;
    @(negedge clk); wr_data = 11'd12;
    chk("b2b_first_addr", 0, 32'(m_addr[0]), 0);
    @(negedge clk); wr_req = 1'b0;
    chk("b2b_second_wren", 0, 32'(m_wren[0]), 1);
    chk("b2b_second_addr", 0, 32'(m_addr[0]), 1);
    cyc(10);
    lit_both("lit_b2b_largest", 0, 12);
    lit_both("lit_b2b_fill", 2, 2);

    // wrap: 100, 31 x 1, then 2 overwrites address 0
    do_reset();
    pulse(100); cyc(2);
    for (int n = 0; n < 31; n++) begin pulse(1); cyc(2); end
    pulse(2);
    @(negedge clk);
    lit_both("lit_wrap_hold", 0, 100);
    lit_both("lit_wrap_fill", 2, 32);
    cyc(40);
    lit_both("lit_wrap_commit", 0, 2);

    // write lands mid-pass at index 4 of 10
    do_reset();
    for (int n = 0; n < 10; n++) begin pulse(scan_vals[n]); cyc(1); end
    k = 0; found = 0;
    while (k < 300 && !found) begin
      @(negedge clk);
      found = (mode[1] == M_PASS && pt[1] == 4 && pn[1] == 10);
      k++;
    end
    chk("reach_scan_idx4", 1, 32'(found), 1);
    wr_req = 1'b1; wr_data = 11'd999;
    @(negedge clk); wr_req = 1'b0;
    @(negedge clk);
    chk("addr_after_abort", 1, 32'(m_addr[1]), 0);
    cyc(30);
    lit_both("lit_abort_fill", 2, 11);
    lit_both("lit_abort_largest", 0, 1200);

    // randomized traffic at several write densities
    for (int seg = 0; seg < 6; seg++) begin
      int rate = (seg % 3 == 0) ? 3 : (seg % 3 == 1) ? 20 : 70;
      for (int n = 0; n < 400; n++) begin
        @(negedge clk);
        wr_req  = ($urandom_range(0, rate - 1) == 0);
        wr_data = SW'($urandom_range(0, (1 << SW) - 1));
      end
    end
    @(negedge clk); wr_req = 1'b0;
    cyc(60);

    // asynchronous reset during DRAIN
    k = 0; found = 0;
    while (k < 300 && !found) begin
      @(negedge clk);
      found = (mode[0] == M_PASS && pt[0] >= pn[0]);
      k++;
    end
    chk("reach_drain", 0, 32'(found), 1);
    chk_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    lit_both("rst_largest", 0, 0);
    lit_both("rst_valid", 1, 0);
    lit_both("rst_fill", 2, 0);
    lit_both("rst_busy", 3, 0);
    for (int i = 0; i < 2; i++) begin
      chk("rst_wren", i, 32'(m_wren[i]), 0);
      chk("rst_addr", i, 32'(m_addr[i]), 0);
      chk("rst_data", i, 32'(m_data[i]), 0);
    end
    cyc(2);
    reset = 1'b1;
    chk_en = 1'b1;
    pulse(77); cyc(10);
    lit_both("lit_post_reset", 0, 77);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
